// File: rtl/motor_pwm_multi.sv
// Multi-channel H-bridge PWM; commands land in shadow registers and take effect at the period wrap.
// Define MOTOR_RAMP_EN to make the active duty ramp toward its target by RAMP_STEP per period.
module motor_pwm_multi #(
  parameter int CHANNELS  = 2,
  parameter int CNT_W     = 12,
  parameter int PERIOD    = 2273,
  parameter int RAMP_STEP = 8
) (
  input  logic                clkus,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_chan,
  input  logic                cmd_dir,
  input  logic [CNT_W-1:0]    cmd_duty,
  input  logic                cmd_stop,
  output logic                cmd_err,
  output logic [CHANNELS-1:0] motor_fwd,
  output logic [CHANNELS-1:0] motor_back,
  output logic [CHANNELS-1:0] motor_en,
  output logic                period_tick
);
  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_DEAD} state_t;

  localparam int DW = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PERIOD - 1);
  localparam logic [DW-1:0]    PERIOD_D = DW'(PERIOD);
  localparam logic [3:0]       CH_N     = 4'(CHANNELS);
`ifdef MOTOR_RAMP_EN
  localparam logic [DW-1:0]    RAMP_D   = DW'(RAMP_STEP);
`endif

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic             r_err;
  logic             w_accept;
  logic             w_wrap;
  logic             w_chan_bad;
  logic [DW-1:0]    w_cmd_duty;

  assign cmd_ready   = rst_n;
  assign w_accept    = cmd_valid && cmd_ready;
  assign w_wrap      = (r_cnt == CNT_MAX);
  assign w_chan_bad  = ({1'b0, cmd_chan} >= CH_N);
  // Duty is one bit wider than the counter so a full-period (100 %) value always fits.
  assign w_cmd_duty  = ({1'b0, cmd_duty} > PERIOD_D) ? PERIOD_D : {1'b0, cmd_duty};
  assign period_tick = r_tick;
  assign cmd_err     = r_err;

  always_ff @(posedge clkus) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
      r_tick <= w_wrap;
      r_err  <= w_accept && w_chan_bad;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic          r_sh_dir;
    logic          r_sh_stop;
    logic [DW-1:0] r_sh_duty;
    state_t        r_state;
    state_t        w_state_next;
    logic          r_dir;
    logic          w_dir_next;
    logic [DW-1:0] r_duty;
    logic [DW-1:0] w_duty_next;
    logic [DW-1:0] w_start;
    logic [DW-1:0] w_toward;
    logic          w_sel;
    logic          w_on;
    logic          r_fwd;
    logic          r_back;
    logic          r_en;

    assign w_sel = w_accept && !w_chan_bad && (cmd_chan == 3'(gi));

    always_ff @(posedge clkus) begin
      if (!rst_n) begin
        r_sh_dir  <= 1'b1;
        r_sh_duty <= '0;
        r_sh_stop <= 1'b1;
      end else if (w_sel) begin
        r_sh_dir  <= cmd_dir;
        r_sh_duty <= w_cmd_duty;
        r_sh_stop <= cmd_stop;
      end
    end

`ifdef MOTOR_RAMP_EN
    logic [DW:0] w_up;
    assign w_up     = {1'b0, r_duty} + {1'b0, RAMP_D};
    assign w_start  = (RAMP_D >= r_sh_duty) ? r_sh_duty : RAMP_D;
    assign w_toward = (r_duty < r_sh_duty)
                      ? ((w_up >= {1'b0, r_sh_duty}) ? r_sh_duty : w_up[DW-1:0])
                      : (((r_duty - r_sh_duty) <= RAMP_D) ? r_sh_duty : r_duty - RAMP_D);
`else
    assign w_start  = r_sh_duty;
    assign w_toward = r_sh_duty;
`endif

    always_ff @(posedge clkus) begin
      if (!rst_n) begin
        r_state <= ST_STOP;
        r_dir   <= 1'b1;
        r_duty  <= '0;
      end else begin
        r_state <= w_state_next;
        r_dir   <= w_dir_next;
        r_duty  <= w_duty_next;
      end
    end

    always_comb begin
      w_state_next = r_state;
      w_dir_next   = r_dir;
      w_duty_next  = r_duty;
      if (w_wrap) begin
        if (r_sh_stop) begin
          w_state_next = ST_STOP;
          w_duty_next  = '0;
        end else begin
          case (r_state)
            ST_STOP: begin
              if (r_sh_duty != '0) begin
                w_state_next = ST_RUN;
                w_dir_next   = r_sh_dir;
                w_duty_next  = w_start;
              end
            end
            ST_RUN: begin
              // A reversal always passes through one dead period with both pins low.
              if (r_sh_dir != r_dir) begin
                w_state_next = ST_DEAD;
                w_duty_next  = '0;
              end else begin
                w_duty_next  = w_toward;
              end
            end
            ST_DEAD: begin
              w_state_next = ST_RUN;
              w_dir_next   = r_sh_dir;
              w_duty_next  = w_start;
            end
            default: begin
              w_state_next = ST_STOP;
              w_duty_next  = '0;
            end
          endcase
        end
      end
    end

    assign w_on = (r_state == ST_RUN) && ({1'b0, r_cnt} < r_duty);

    always_ff @(posedge clkus) begin
      if (!rst_n) begin
        r_fwd  <= 1'b0;
        r_back <= 1'b0;
        r_en   <= 1'b0;
      end else begin
        r_fwd  <= w_on && r_dir;
        r_back <= w_on && !r_dir;
        r_en   <= (r_state != ST_STOP);
      end
    end

    assign motor_fwd[gi]  = r_fwd;
    assign motor_back[gi] = r_back;
    assign motor_en[gi]   = r_en;
  end

endmodule

// File: tb/tb_motor_pwm_multi.sv
// Self-checking bench for motor_pwm_multi: directed vector table, corner sequences, and
// randomized commands checked cycle by cycle against a period-level reference model.
module tb_motor_pwm_multi;
  localparam int CHANNELS  = 2;
  localparam int CNT_W     = 12;
  localparam int PERIOD    = 100;
  localparam int RAMP_STEP = 10;
  localparam int M_STOP = 0, M_RUN = 1, M_DEAD = 2;
`ifdef MOTOR_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif
  localparam int SETTLE = RAMP ? 16 : 3;

  logic                clkus = 1'b0;
  logic                rst_n;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [2:0]          cmd_chan;
  logic                cmd_dir;
  logic [CNT_W-1:0]    cmd_duty;
  logic                cmd_stop;
  logic                cmd_err;
  logic [CHANNELS-1:0] motor_fwd;
  logic [CHANNELS-1:0] motor_back;
  logic [CHANNELS-1:0] motor_en;
  logic                period_tick;

  motor_pwm_multi #(
    .CHANNELS(CHANNELS), .CNT_W(CNT_W), .PERIOD(PERIOD), .RAMP_STEP(RAMP_STEP)
  ) dut (
    .clkus(clkus), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_chan(cmd_chan), .cmd_dir(cmd_dir), .cmd_duty(cmd_duty), .cmd_stop(cmd_stop),
    .cmd_err(cmd_err), .motor_fwd(motor_fwd), .motor_back(motor_back),
    .motor_en(motor_en), .period_tick(period_tick)
  );

  always #5 clkus = ~clkus;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: counter position, per-channel mode/dir/duty, shadow command values.
  int m_cnt = 0;
  int m_mode[CHANNELS];
  int m_dir[CHANNELS];
  int m_duty[CHANNELS];
  int sh_dir[CHANNELS];
  int sh_duty[CHANNELS];
  int sh_stop[CHANNELS];
  logic [CHANNELS-1:0] e_fwd = '0, e_back = '0, e_en = '0;
  logic e_tick = 1'b0, e_err = 1'b0;

  int acc_f[CHANNELS];
  int acc_b[CHANNELS];
  int acc_e[CHANNELS];
  int acc_ov;

  typedef struct {
    int chan; int dir; int duty; int stop;
    int f0; int b0; int e0; int f1; int b1; int e1;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic int toward(input int cur, input int tgt);
`ifdef MOTOR_RAMP_EN
    if (cur < tgt) return (cur + RAMP_STEP > tgt) ? tgt : cur + RAMP_STEP;
    return (cur - RAMP_STEP < tgt) ? tgt : cur - RAMP_STEP;
`else
    return tgt + 0 * cur;
`endif
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_cnt = 0;
      for (int c = 0; c < CHANNELS; c++) begin
        m_mode[c] = M_STOP; m_dir[c] = 1; m_duty[c] = 0;
        sh_dir[c] = 1; sh_duty[c] = 0; sh_stop[c] = 1;
      end
      e_fwd = '0; e_back = '0; e_en = '0; e_tick = 1'b0; e_err = 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        e_fwd[c]  = (m_mode[c] == M_RUN) && (m_dir[c] == 1) && (m_cnt < m_duty[c]);
        e_back[c] = (m_mode[c] == M_RUN) && (m_dir[c] == 0) && (m_cnt < m_duty[c]);
        e_en[c]   = (m_mode[c] != M_STOP);
      end
      e_tick = (m_cnt == PERIOD - 1);
      e_err  = cmd_valid && (int'(cmd_chan) >= CHANNELS);
      if (m_cnt == PERIOD - 1) begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (sh_stop[c] != 0) begin
            m_mode[c] = M_STOP; m_duty[c] = 0;
          end else if (m_mode[c] == M_STOP) begin
            if (sh_duty[c] > 0) begin
              m_mode[c] = M_RUN; m_dir[c] = sh_dir[c]; m_duty[c] = toward(0, sh_duty[c]);
            end
          end else if (m_mode[c] == M_RUN) begin
            if (sh_dir[c] != m_dir[c]) begin
              m_mode[c] = M_DEAD; m_duty[c] = 0;
            end else m_duty[c] = toward(m_duty[c], sh_duty[c]);
          end else begin
            m_mode[c] = M_RUN; m_dir[c] = sh_dir[c]; m_duty[c] = toward(0, sh_duty[c]);
          end
        end
      end
      if (cmd_valid && int'(cmd_chan) < CHANNELS) begin
        sh_dir[cmd_chan]  = int'(cmd_dir);
        sh_duty[cmd_chan] = (int'(cmd_duty) > PERIOD) ? PERIOD : int'(cmd_duty);
        sh_stop[cmd_chan] = int'(cmd_stop);
      end
      m_cnt = (m_cnt + 1) % PERIOD;
    end
  endtask

  task automatic step();
    logic [8:0] act, ev;
    @(posedge clkus);
    model_edge();
    @(negedge clkus);
    cyc++;
    act = {period_tick, cmd_err, cmd_ready, motor_en, motor_fwd, motor_back};
    ev  = {e_tick, e_err, rst_n, e_en, e_fwd, e_back};
    chk($sformatf("cycle%0d", cyc), int'(act), int'(ev));
    for (int c = 0; c < CHANNELS; c++) begin
      acc_f[c] += int'(motor_fwd[c]);
      acc_b[c] += int'(motor_back[c]);
      acc_e[c] += int'(motor_en[c]);
    end
    acc_ov += int'(|(motor_fwd & motor_back));
  endtask

  task automatic send(input int ch, input int dir, input int duty, input int stop);
    cmd_valid = 1'b1; cmd_chan = 3'(ch); cmd_dir = 1'(dir);
    cmd_duty = CNT_W'(duty); cmd_stop = 1'(stop);
    $display("cmd cyc=%0d cnt=%0d ch=%0d dir=%0d duty=%0d stop=%0d", cyc, m_cnt, ch, dir, duty, stop);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic align();
    while (m_cnt != 0) step();
  endtask

  // Captures exactly one output period; call with the model counter at 0.
  task automatic measure();
    for (int c = 0; c < CHANNELS; c++) begin
      acc_f[c] = 0; acc_b[c] = 0; acc_e[c] = 0;
    end
    acc_ov = 0;
    repeat (PERIOD) step();
  endtask

  initial begin
    int got;
    int rst_at;
    tbl[0] = '{0, 1,  30, 0,  30,   0, 100,   0,  0,   0};
    tbl[1] = '{1, 0,  35, 0,  30,   0, 100,   0, 35, 100};
    tbl[2] = '{0, 0,  50, 0,   0,  50, 100,   0, 35, 100};
    tbl[3] = '{0, 0, 150, 0,   0, 100, 100,   0, 35, 100};
    tbl[4] = '{1, 1,   0, 0,   0, 100, 100,   0,  0, 100};
    tbl[5] = '{5, 1,  20, 0,   0, 100, 100,   0,  0, 100};
    tbl[6] = '{1, 1,  70, 1,   0, 100, 100,   0,  0,   0};
    tbl[7] = '{0, 1, 100, 0, 100,   0, 100,   0,  0,   0};
    tbl[8] = '{0, 1,  60, 1,   0,   0,   0,   0,  0,   0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_chan = '0; cmd_dir = 1'b0; cmd_duty = '0; cmd_stop = 1'b0;
    repeat (3) step();
    chk("rst_fwd", int'(motor_fwd), 0);
    chk("rst_back", int'(motor_back), 0);
    chk("rst_en", int'(motor_en), 0);
    chk("rst_tick", int'(period_tick), 0);
    chk("rst_err", int'(cmd_err), 0);
    chk("rst_ready", int'(cmd_ready), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      repeat (PERIOD / 3) step();
      send(tbl[i].chan, tbl[i].dir, tbl[i].duty, tbl[i].stop);
      chk($sformatf("v%0d_err", i), int'(cmd_err), (tbl[i].chan >= CHANNELS) ? 1 : 0);
      repeat (SETTLE * PERIOD) step();
      align();
      measure();
      chk($sformatf("v%0d_fwd0", i), acc_f[0], tbl[i].f0);
      chk($sformatf("v%0d_back0", i), acc_b[0], tbl[i].b0);
      chk($sformatf("v%0d_en0", i), acc_e[0], tbl[i].e0);
      chk($sformatf("v%0d_fwd1", i), acc_f[1], tbl[i].f1);
      chk($sformatf("v%0d_back1", i), acc_b[1], tbl[i].b1);
      chk($sformatf("v%0d_en1", i), acc_e[1], tbl[i].e1);
      chk($sformatf("v%0d_overlap", i), acc_ov, 0);
    end

    // Reversal: one dead period with the driver enabled and both pins low.
    repeat (PERIOD / 3) step();
    send(0, 1, 50, 0);
    repeat (SETTLE * PERIOD) step();
    align();
    repeat (20) step();
    send(0, 0, 50, 0);
    align();
    measure();
    chk("dead_en0", acc_e[0], 100);
    chk("dead_pins0", acc_f[0] + acc_b[0], 0);
    measure();
    chk("after_dead_back0", acc_b[0], RAMP ? 10 : 50);
    chk("after_dead_fwd0", acc_f[0], 0);
    chk("after_dead_overlap", acc_ov, 0);

    // Command accepted on the wrap cycle waits for the following wrap; duty clamps to full.
    send(0, 1, 0, 1);
    repeat (2 * PERIOD) step();
    while (m_cnt != PERIOD - 1) step();
    send(0, 1, 150, 0);
    measure();
    chk("late_cmd_en0", acc_e[0], 0);
    chk("late_cmd_fwd0", acc_f[0], 0);
    measure();
    chk("late_cmd_applied_fwd0", acc_f[0], RAMP ? 10 : 100);
    chk("late_cmd_applied_en0", acc_e[0], 100);

    // Stop on a running channel, then reset in the middle of a period.
    send(1, 1, 40, 0);
    repeat (SETTLE * PERIOD) step();
    align();
    repeat (10) step();
    send(1, 1, 40, 1);
    align();
    measure();
    chk("stop_en1", acc_e[1], 0);
    chk("stop_fwd1", acc_f[1], 0);
    repeat (37) step();
    rst_n = 1'b0;
    step();
    chk("rst_mid_outputs",
        int'({motor_fwd, motor_back, motor_en, period_tick, cmd_err, cmd_ready}), 0);
    repeat (2) step();
    rst_n = 1'b1;
    got = -1;
    for (int k = 1; k <= 250; k++) begin
      step();
      if (period_tick) begin
        got = k;
        break;
      end
    end
    chk("first_wrap_after_reset", got, PERIOD);

    // Randomized commands, including bad channels and one short reset.
    rst_at = int'($urandom_range(1000, 2000));
    for (int k = 0; k < 3000; k++) begin
      if (k == rst_at) rst_n = 1'b0;
      if (k == rst_at + 3) rst_n = 1'b1;
      if ($urandom_range(0, 9) == 0) begin
        send(($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 7)) : int'($urandom_range(0, 1)),
             int'($urandom_range(0, 1)), int'($urandom_range(0, 160)),
             ($urandom_range(0, 5) == 0) ? 1 : 0);
      end else begin
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
